// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus: byte-wide instruction memory port, redirect input and the
// valid/ready instruction stream toward the datapath.
interface inst_fetch_queue_if #(
  parameter int unsigned AW = 5
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic [31:0]   fetch_pc;

  // Fetch unit side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready,
    output fetch_pc
  );

  // Memory and datapath side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready,
    input  fetch_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words from a
// byte-wide memory and queues them with their PC in a small prefetch FIFO.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_queue_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic          full;
  logic          fetch_en;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [31:0]   new_word;
  logic          unused_redirect_pc_lsb;

  assign unused_redirect_pc_lsb = ^bus.redirect_pc[1:0];

  assign full       = (count_q == CW'(DEPTH));
  assign head_valid = (count_q != '0);
  // Full is judged on the registered count, so a pop while full frees the
  // slot for the next cycle only.
  assign fetch_en   = rst_n & ~bus.redirect & ~full;
  assign push       = fetch_en & (byte_cnt_q == 2'd3);
  assign pop        = head_valid & bus.inst_ready;
  assign new_word   = {asm_q, bus.imem_rdata};

  // Next-state logic; redirect overrides fetch and pop bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      byte_cnt_d = 2'd0;
      asm_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (fetch_en) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        unique case (byte_cnt_q)
          2'd0:    asm_d[23:16] = bus.imem_rdata;
          2'd1:    asm_d[15:8]  = bus.imem_rdata;
          2'd2:    asm_d[7:0]   = bus.imem_rdata;
          default: fetch_pc_d   = fetch_pc_q + 32'd4;
        endcase
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= new_word;
      fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  always_comb begin
    bus.imem_req   = fetch_en;
    bus.imem_addr  = fetch_pc_q[AW-1:0] + AW'(byte_cnt_q);
    bus.inst_valid = head_valid;
    bus.inst       = head_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    bus.inst_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    bus.fetch_pc   = fetch_pc_q;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, fill/stall, drain, redirect,
// back-to-back redirect and asynchronous reset mid-word.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.AW(5)) bus ();

  logic [7:0] mem [32];
  assign bus.imem_rdata = mem[bus.imem_addr];

  inst_fetch_queue #(
    .DEPTH    (4),
    .AW       (5),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
    mem[4] = 8'h10; mem[5] = 8'h21; mem[6] = 8'hFF; mem[7] = 8'hFE;

    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready = 1'b0;
    #1;
    chk("rst_req",      bus.imem_req,   32'h0);
    chk("rst_valid",    bus.inst_valid, 32'h0);
    chk("rst_inst",     bus.inst,       32'h0);
    chk("rst_inst_pc",  bus.inst_pc,    32'h0);
    chk("rst_fetch_pc", bus.fetch_pc,   32'h0);

    step(); step();
    rst_n = 1'b1;
    // cycle 1
    #1;
    chk("c1_req",  bus.imem_req,   32'h1);
    chk("c1_addr", bus.imem_addr,  32'h0);
    chk("c1_valid", bus.inst_valid, 32'h0);
    step(); chk("c2_addr", bus.imem_addr, 32'h1);
    step(); chk("c3_addr", bus.imem_addr, 32'h2);
    step(); chk("c4_addr", bus.imem_addr, 32'h3);
    chk("c4_valid", bus.inst_valid, 32'h0);
    step();
    chk("c5_valid",    bus.inst_valid, 32'h1);
    chk("c5_inst",     bus.inst,       32'h8C220004);
    chk("c5_inst_pc",  bus.inst_pc,    32'h0);
    chk("c5_addr",     bus.imem_addr,  32'h4);
    chk("c5_fetch_pc", bus.fetch_pc,   32'h4);
    repeat (4) step();
    chk("c9_addr",    bus.imem_addr, 32'h8);
    chk("c9_inst_pc", bus.inst_pc,   32'h0);

    // Fill to DEPTH with no consumer.
    repeat (8) step();
    chk("full_req",      bus.imem_req,  32'h0);
    chk("full_fetch_pc", bus.fetch_pc,  32'h10);
    chk("full_addr",     bus.imem_addr, 32'h10);
    step();
    chk("full_req2", bus.imem_req, 32'h0);
    bus.inst_ready = 1'b1;
    #1;
    chk("pop_full_req", bus.imem_req, 32'h0);

    // Resume after pop-while-full, then drain with ready held high.
    step();
    chk("resume_req",     bus.imem_req,  32'h1);
    chk("resume_addr",    bus.imem_addr, 32'h10);
    chk("resume_inst_pc", bus.inst_pc,   32'h4);
    chk("resume_inst",    bus.inst,      32'h1021FFFE);
    step();
    chk("drain_pc8",   bus.inst_pc, 32'h8);
    chk("drain_inst8", bus.inst,    32'hA8A9AAAB);
    step(); chk("drain_pcC", bus.inst_pc, 32'hC);
    step();
    chk("empty_valid",   bus.inst_valid, 32'h0);
    chk("empty_inst",    bus.inst,       32'h0);
    chk("empty_inst_pc", bus.inst_pc,    32'h0);
    step();
    chk("ss_pc10",   bus.inst_pc, 32'h10);
    chk("ss_inst10", bus.inst,    32'hB0B1B2B3);
    step(); chk("ss_gap_valid", bus.inst_valid, 32'h0);
    repeat (3) step(); chk("ss_pc14", bus.inst_pc, 32'h14);
    repeat (4) step();
    chk("ss_pc18",    bus.inst_pc,    32'h18);
    chk("ss_valid18", bus.inst_valid, 32'h1);

    // Redirect together with a completing handshake; low PC bits ignored.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_000B;
    #1;
    chk("redir_req", bus.imem_req, 32'h0);
    step();
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b0;
    #1;
    chk("redir_valid",    bus.inst_valid, 32'h0);
    chk("redir_inst",     bus.inst,       32'h0);
    chk("redir_fetch_pc", bus.fetch_pc,   32'h8);
    chk("redir_addr",     bus.imem_addr,  32'h8);
    chk("redir_req2",     bus.imem_req,   32'h1);
    step(); chk("redir_addr9", bus.imem_addr, 32'h9);
    step(); chk("redir_addrA", bus.imem_addr, 32'hA);

    // Redirect mid-word to 0x1E, word at 0x1C wraps fetch to 0x00.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_001E;
    #1;
    chk("mid_redir_req", bus.imem_req, 32'h0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("mid_valid",    bus.inst_valid, 32'h0);
    chk("mid_fetch_pc", bus.fetch_pc,   32'h1C);
    chk("mid_addr1C",   bus.imem_addr,  32'h1C);
    step(); chk("mid_addr1D", bus.imem_addr, 32'h1D);
    step(); chk("mid_addr1E", bus.imem_addr, 32'h1E);
    step(); chk("mid_addr1F", bus.imem_addr, 32'h1F);
    step();
    chk("wrap_valid",    bus.inst_valid, 32'h1);
    chk("wrap_inst_pc",  bus.inst_pc,    32'h1C);
    chk("wrap_inst",     bus.inst,       32'hBCBDBEBF);
    chk("wrap_fetch_pc", bus.fetch_pc,   32'h20);
    chk("wrap_addr",     bus.imem_addr,  32'h0);

    // Back-to-back redirects: only the last target is fetched.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h4;
    step();
    bus.redirect_pc = 32'hC;
    step();
    bus.redirect = 1'b0;
    #1;
    chk("b2b_fetch_pc", bus.fetch_pc,   32'hC);
    chk("b2b_addr",     bus.imem_addr,  32'hC);
    chk("b2b_valid",    bus.inst_valid, 32'h0);
    repeat (4) step();
    chk("b2b_inst_pc", bus.inst_pc, 32'hC);
    chk("b2b_inst",    bus.inst,    32'hACADAEAF);

    // Build count=3 with a word in progress, then reset asynchronously.
    repeat (9) step();
    chk("pre_rst_addr",    bus.imem_addr, 32'h19);
    chk("pre_rst_inst_pc", bus.inst_pc,   32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",      bus.imem_req,   32'h0);
    chk("arst_valid",    bus.inst_valid, 32'h0);
    chk("arst_inst",     bus.inst,       32'h0);
    chk("arst_inst_pc",  bus.inst_pc,    32'h0);
    chk("arst_fetch_pc", bus.fetch_pc,   32'h0);
    chk("arst_addr",     bus.imem_addr,  32'h0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rel_req",  bus.imem_req,  32'h1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    repeat (3) step();
    chk("rel_c4_valid", bus.inst_valid, 32'h0);
    step();
    chk("rel_c5_inst",    bus.inst,    32'h8C220004);
    chk("rel_c5_inst_pc", bus.inst_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
